// File: rtl/reg_file_dumper_pkg.sv
// Shared definitions for the register-file scan-out engine: default geometry and FSM encoding.
// The state values match the encodings used by reg_file and the CPU datapath.
package reg_file_dumper_pkg;

  localparam int NREGS_DEF         = 8;
  localparam int AW_DEF            = 3;
  localparam int DW_DEF            = 8;
  localparam int SETTLE_CYCLES_DEF = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2,
    FIN    = 2'd3
  } dump_state_t;

  // Width needed to hold the settle reload value; never narrower than one bit.
  function automatic int settle_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/reg_file_dumper.sv
// Debug scan-out engine: walks a block of register-file addresses and streams {addr, data} out.
// START to first DOUT_VALID is 1+SETTLE_CYCLES edges; SEND holds DOUT/RD_ADDR frozen until DOUT_READY.
module reg_file_dumper
  import reg_file_dumper_pkg::*;
#(
  parameter int NREGS         = NREGS_DEF,
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [AW-1:0] BASE_ADDR,
  input  logic [AW:0]   COUNT,
  output logic [AW-1:0] RD_ADDR,
  input  logic [DW-1:0] RD_DATA,
  output logic [DW-1:0] DOUT,
  output logic [AW-1:0] DOUT_ADDR,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic          BUSY,
  output logic          DONE,
  output logic [DW-1:0] CHECKSUM
);

  localparam int            SW          = settle_width(SETTLE_CYCLES);
  localparam logic [AW:0]   NREGS_W     = (AW+1)'(NREGS);
  localparam logic [AW:0]   REM_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE    = AW'(1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

  dump_state_t   state;
  dump_state_t   state_nxt;
  logic [AW:0]   remaining;
  logic [AW:0]   eff_count;
  logic [SW-1:0] settle_cnt;

  logic start_dump;
  logic start_empty;
  logic capture;
  logic xfer;
  logic last_xfer;

  // Requests larger than the file are clamped so each register is read at most once.
  always_comb begin
    eff_count = COUNT;
    if (COUNT > NREGS_W) begin
      eff_count = NREGS_W;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_dump  = 1'b0;
    start_empty = 1'b0;
    capture     = 1'b0;
    xfer        = 1'b0;
    last_xfer   = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          if (eff_count != '0) begin
            start_dump = 1'b1;
            state_nxt  = SETTLE;
          end else begin
            start_empty = 1'b1;
            state_nxt   = FIN;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt <= SETTLE_ONE) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (DOUT_VALID && DOUT_READY) begin
          xfer = 1'b1;
          if (remaining == REM_ONE) begin
            last_xfer = 1'b1;
            state_nxt = FIN;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      RD_ADDR    <= '0;
      DOUT       <= '0;
      DOUT_ADDR  <= '0;
      DOUT_VALID <= 1'b0;
      BUSY       <= 1'b0;
      CHECKSUM   <= '0;
      remaining  <= '0;
      settle_cnt <= '0;
    end else begin
      if (start_dump) begin
        RD_ADDR    <= BASE_ADDR;
        remaining  <= eff_count;
        settle_cnt <= SETTLE_LOAD;
        CHECKSUM   <= '0;
        BUSY       <= 1'b1;
      end
      if (start_empty) begin
        CHECKSUM <= '0;
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt - SETTLE_ONE;
      end
      // The value present at the capture edge wins, even if a CPU write just landed.
      if (capture) begin
        DOUT       <= RD_DATA;
        DOUT_ADDR  <= RD_ADDR;
        DOUT_VALID <= 1'b1;
      end
      if (xfer) begin
        CHECKSUM   <= CHECKSUM + DOUT;
        DOUT_VALID <= 1'b0;
        remaining  <= remaining - REM_ONE;
        if (!last_xfer) begin
          RD_ADDR    <= RD_ADDR + ADDR_ONE;
          settle_cnt <= SETTLE_LOAD;
        end
      end
      if (state == FIN) begin
        BUSY <= 1'b0;
      end
    end
  end

  assign DONE = (state == FIN);

endmodule
